// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller.
//   state_t : controller FSM encoding (IDLE=0, RUN=1, DONE=2), 2 bits
//   DIGIT_W : width of one digit handled per cycle by the adder
package nibble_serial_add_ctrl_pkg;

   localparam int DIGIT_W = 4;
   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/nibble_serial_add_ctrl_adder.sv
// Combinational digit adder used by the serial controller.
//   a, b : DIGIT_W-bit addends
//   cin  : carry in
//   s    : DIGIT_W-bit sum
//   cout : carry out of the top bit
module nibble_serial_add_ctrl_adder
   import nibble_serial_add_ctrl_pkg::*;
(
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   input  logic               cin,
   output logic [DIGIT_W-1:0] s,
   output logic               cout
);

   // carry[gi] is the carry into bit gi; carry[DIGIT_W] leaves the digit.
   logic [DIGIT_W:0] carry;

   assign carry[0] = cin;

   genvar gi;
   generate
      for (gi = 0; gi < DIGIT_W; gi++) begin : g_bit
         assign s[gi]        = a[gi] ^ b[gi] ^ carry[gi];
         assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
      end
   endgenerate

   assign cout = carry[DIGIT_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder controller.
// Accepts an operand set (a, b, cin) in IDLE, then spends NIBBLES cycles in
// RUN feeding one digit per cycle (LSB first) through a single digit adder,
// and finally presents the sum in DONE until the consumer takes it.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   a, b, cin           : operands (W = 4*NIBBLES bits) and initial carry
//   out_valid/out_ready : result handshake
//   s, cout             : sum modulo 2^W and final carry
//   busy                : high whenever the FSM is not in IDLE
module nibble_serial_add_ctrl
   import nibble_serial_add_ctrl_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DIGIT_W*NIBBLES-1:0] a,
   input  logic [DIGIT_W*NIBBLES-1:0] b,
   input  logic                     cin,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DIGIT_W*NIBBLES-1:0] s,
   output logic                     cout,
   output logic                     busy
);

   localparam int W     = DIGIT_W * NIBBLES;
   localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

   state_t             state_reg, state_next;
   logic [W-1:0]       a_reg, b_reg, s_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic               carry_reg;
   logic               cout_reg;
   logic               out_valid_reg;

   logic [DIGIT_W-1:0] dig_s;
   logic               dig_c;
   logic [W-1:0]       s_shift;
   logic               accept;
   logic               take;

   nibble_serial_add_ctrl_adder u_adder (
      .a    (a_reg[DIGIT_W-1:0]),
      .b    (b_reg[DIGIT_W-1:0]),
      .cin  (carry_reg),
      .s    (dig_s),
      .cout (dig_c)
   );

   assign accept  = in_valid && (state_reg == IDLE);
   // The result is only taken once out_valid is actually visible.
   assign take    = (state_reg == DONE) && out_valid_reg && out_ready;
   // New digit enters at the top; after NIBBLES shifts digit 0 sits at the LSB.
   assign s_shift = (s_reg >> DIGIT_W) | (W'(dig_s) << (W - DIGIT_W));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = RUN;
         RUN:     if (cnt_reg == CNT_LAST) state_next = DONE;
         DONE:    if (take) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg         <= '0;
         b_reg         <= '0;
         s_reg         <= '0;
         cnt_reg       <= '0;
         carry_reg     <= 1'b0;
         cout_reg      <= 1'b0;
         out_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  a_reg     <= a;
                  b_reg     <= b;
                  carry_reg <= cin;
                  cnt_reg   <= '0;
               end
            end
            RUN: begin
               a_reg     <= a_reg >> DIGIT_W;
               b_reg     <= b_reg >> DIGIT_W;
               carry_reg <= dig_c;
               s_reg     <= s_shift;
               if (cnt_reg != CNT_LAST) begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end else begin
                  cout_reg <= dig_c;
               end
            end
            DONE: begin
               // out_valid rises one edge into DONE so it lands NIBBLES+1
               // edges after the accept edge, then holds until taken.
               out_valid_reg <= !take;
            end
            default: begin
               out_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = (state_reg == IDLE);
   assign busy      = (state_reg != IDLE);
   assign out_valid = out_valid_reg;
   assign s         = s_reg;
   assign cout      = cout_reg;

endmodule
